// File: rtl/mig_model_pkg.sv
// Shared definitions for the behavioural MIG memory-controller model.
// Holds the application command encodings and the controller FSM state type.
package mig_model_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    StCalib   = 2'd0,
    StRun     = 2'd1,
    StRefresh = 2'd2
  } mig_state_e;

endpackage

// File: rtl/sync_fifo_p.sv
// Generic single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset (clears pointers only)
//   wr_en_i, wr_data_i  push (ignored when full)
//   rd_en_i, rd_data_o  pop (ignored when empty); rd_data_o shows the head entry
//   full_o, empty_o     occupancy flags, derived from registered pointers only
module sync_fifo_p #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4   // power of 2, at least 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               push, pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/dummy_mig_model.sv
// Behavioural stand-in for a DDR memory controller user interface.
// Commands and write data are queued separately, paired in order and retired one per cycle
// into an internal 128-bit memory; reads return after a fixed pipeline latency.
// Ports:
//   mclk, mrst                          clock, asynchronous active-high reset
//   app_addr/app_cmd/app_en/app_rdy     command channel (000 write, 001 read)
//   app_wdf_data/mask/wren/end/rdy      write-data channel (mask bit 1 = byte kept)
//   app_rd_data/valid/end               read-response channel, no backpressure
//   init_calib_complete                 high once the calibration delay has elapsed
module dummy_mig_model
  import mig_model_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned CQ_DEPTH   = 4,
  parameter int unsigned WDF_DEPTH  = 4,
  parameter int unsigned CALIB_CYC  = 16,
  parameter int unsigned REF_PERIOD = 256,
  parameter int unsigned REF_CYC    = 8
) (
  input  logic                mclk,
  input  logic                mrst,
  input  logic [27:0]         app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [MASK_W-1:0]   app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete
);

  localparam int unsigned Words     = 2 ** ADDR_W;
  localparam int unsigned CqW       = ADDR_W + 1;          // {is_read, word index}
  localparam int unsigned WdfW      = MASK_W + DATA_W;     // {mask, data}
  localparam int unsigned CalibLast = (CALIB_CYC  > 0) ? CALIB_CYC  - 1 : 0;
  localparam int unsigned RefLast   = (REF_PERIOD > 0) ? REF_PERIOD - 1 : 0;
  localparam int unsigned StallLast = (REF_CYC    > 0) ? REF_CYC    - 1 : 0;

  // Burst-end strobe and the address bits outside the word index carry no information here.
  logic unused_bits;
  assign unused_bits = ^{app_wdf_end, app_addr};

  // ---------------------------------------------------------------------------
  // Calibration / refresh FSM
  // ---------------------------------------------------------------------------
  mig_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        calib_done_q, calib_done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    calib_done_d = calib_done_q;
    case (state_q)
      StCalib: begin
        if (cnt_q == 32'(CalibLast)) begin
          state_d      = StRun;
          cnt_d        = '0;
          calib_done_d = 1'b1;
        end
      end
      StRun: begin
        if (REF_PERIOD == 0) begin
          cnt_d = cnt_q;
        end else if (cnt_q == 32'(RefLast)) begin
          state_d = StRefresh;
          cnt_d   = '0;
        end
      end
      StRefresh: begin
        if (cnt_q == 32'(StallLast)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StCalib;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q      <= StCalib;
      cnt_q        <= '0;
      calib_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      calib_done_q <= calib_done_d;
    end
  end

  assign init_calib_complete = calib_done_q;

  // ---------------------------------------------------------------------------
  // Command queue and write-data FIFO
  // ---------------------------------------------------------------------------
  logic            cq_full, cq_empty, cq_push, cq_pop;
  logic [CqW-1:0]  cq_wr_data, cq_head;
  logic            wdf_full, wdf_empty, wdf_push, wdf_pop;
  logic [WdfW-1:0] wdf_head;

  // Ready depends only on registered state, so a slot freed by this cycle's retire
  // becomes visible to the requester one cycle later.
  assign app_rdy     = calib_done_q && !cq_full && (state_q != StRefresh);
  assign app_wdf_rdy = calib_done_q && !wdf_full;

  // Unknown commands are handshaken but dropped.
  assign cq_push    = app_en && app_rdy && ((app_cmd == CMD_WR) || (app_cmd == CMD_RD));
  assign cq_wr_data = {(app_cmd == CMD_RD), app_addr[ADDR_W+2:3]};
  assign wdf_push   = app_wdf_wren && app_wdf_rdy;

  sync_fifo_p #(
    .Width (CqW),
    .Depth (CQ_DEPTH)
  ) u_cmd_q (
    .clk_i     (mclk),
    .rst_i     (mrst),
    .wr_en_i   (cq_push),
    .wr_data_i (cq_wr_data),
    .rd_en_i   (cq_pop),
    .rd_data_o (cq_head),
    .full_o    (cq_full),
    .empty_o   (cq_empty)
  );

  sync_fifo_p #(
    .Width (WdfW),
    .Depth (WDF_DEPTH)
  ) u_wdf (
    .clk_i     (mclk),
    .rst_i     (mrst),
    .wr_en_i   (wdf_push),
    .wr_data_i ({app_wdf_mask, app_wdf_data}),
    .rd_en_i   (wdf_pop),
    .rd_data_o (wdf_head),
    .full_o    (wdf_full),
    .empty_o   (wdf_empty)
  );

  // ---------------------------------------------------------------------------
  // Retirement: in order, one per cycle; a head write waits for its data beat.
  // ---------------------------------------------------------------------------
  logic              head_rd, retire, rd_retire;
  logic [ADDR_W-1:0] head_word;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_data;

  assign head_rd   = cq_head[ADDR_W];
  assign head_word = cq_head[ADDR_W-1:0];
  assign wr_mask   = wdf_head[WdfW-1:DATA_W];
  assign wr_data   = wdf_head[DATA_W-1:0];

  assign retire    = (state_q == StRun) && !cq_empty && (head_rd || !wdf_empty);
  assign rd_retire = retire && head_rd;
  assign cq_pop    = retire;
  assign wdf_pop   = retire && !head_rd;

  // Memory is deliberately left uninitialised and survives reset.
  logic [DATA_W-1:0] mem_q [Words];

  always_ff @(posedge mclk) begin
    if (wdf_pop) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (!wr_mask[b]) mem_q[head_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-response pipeline: retire happens one cycle after accept, so RD_LAT stages
  // place the response exactly RD_LAT cycles after the accepting edge.
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0] rd_vld_q;
  logic [DATA_W-1:0] rd_data_q [RD_LAT];

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      rd_vld_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) rd_data_q[i] <= '0;
    end else begin
      rd_vld_q     <= {rd_vld_q[RD_LAT-2:0], rd_retire};
      rd_data_q[0] <= rd_retire ? mem_q[head_word] : rd_data_q[0];
      for (int i = 1; i < int'(RD_LAT); i++) rd_data_q[i] <= rd_data_q[i-1];
    end
  end

  assign app_rd_data       = rd_data_q[RD_LAT-1];
  assign app_rd_data_valid = rd_vld_q[RD_LAT-1];
  assign app_rd_data_end   = rd_vld_q[RD_LAT-1];

endmodule

// File: tb/tb_dummy_mig_model.sv
// Self-checking bench for dummy_mig_model: read responses are checked against a
// scoreboard queue filled when each read command is accepted.
module tb_dummy_mig_model;

  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic         mclk = 1'b0;
  logic         mrst = 1'b1;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;

  dummy_mig_model #(
    .ADDR_W     (10),
    .RD_LAT     (4),
    .CQ_DEPTH   (4),
    .WDF_DEPTH  (4),
    .CALIB_CYC  (16),
    .REF_PERIOD (32),
    .REF_CYC    (8)
  ) dut (
    .mclk                (mclk),
    .mrst                (mrst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_seen = 0;
  int last_valid_cyc = 0;
  int acc_cyc = 0;
  logic [127:0] exp_q [$];
  logic [127:0] model [int];

  function automatic int widx(input logic [27:0] a);
    return int'((a >> 3) & 28'h3FF);
  endfunction

  function automatic logic [127:0] apply(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] m);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (!m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One clock step; samples 1 time unit after the rising edge and checks any response.
  task automatic tick();
    logic [127:0] e;
    @(posedge mclk);
    #1;
    cyc++;
    if (app_rd_data_valid === 1'b1) begin
      rd_seen++;
      last_valid_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got valid data %h, required no response", app_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (app_rd_data !== e || app_rd_data_end !== 1'b1) begin
          bad++;
          $display("FAIL rd_data: got %h end=%b, required %h end=1", app_rd_data,
                   app_rd_data_end, e);
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [27:0] addr, output bit ok);
    int budget;
    logic rdy_before;
    app_cmd = cmd;
    app_addr = addr;
    app_en = 1'b1;
    budget = 0;
    do begin
      rdy_before = app_rdy;
      tick();
      budget++;
    end while (rdy_before !== 1'b1 && budget < 200);
    app_en = 1'b0;
    ok = (rdy_before === 1'b1);
    acc_cyc = cyc;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL cmd_accept: app_rdy stayed %b, required 1 within 200 cycles", app_rdy);
    end
  endtask

  task automatic rd_exp(input logic [27:0] addr, input logic [127:0] e);
    bit ok;
    issue(RD, addr, ok);
    if (ok) exp_q.push_back(e);
  endtask

  task automatic rd(input logic [27:0] addr);
    rd_exp(addr, model.exists(widx(addr)) ? model[widx(addr)] : 'x);
  endtask

  task automatic wr_cmd(input logic [27:0] addr, input logic [127:0] d, input logic [15:0] m);
    bit ok;
    logic [127:0] old;
    issue(WR, addr, ok);
    old = model.exists(widx(addr)) ? model[widx(addr)] : 'x;
    model[widx(addr)] = apply(old, d, m);
  endtask

  task automatic wr_data(input logic [127:0] d, input logic [15:0] m);
    int budget;
    logic rdy_before;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    budget = 0;
    do begin
      rdy_before = app_wdf_rdy;
      tick();
      budget++;
    end while (rdy_before !== 1'b1 && budget < 200);
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
    if (rdy_before !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wdf_accept: app_wdf_rdy stayed %b, required 1", app_wdf_rdy);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Align to the start of a run window so short sequences see no refresh stall.
  task automatic sync_refresh();
    int budget;
    budget = 0;
    while (app_rdy !== 1'b0 && budget < 100) begin tick(); budget++; end
    while (app_rdy !== 1'b1 && budget < 200) begin tick(); budget++; end
    if (budget >= 200) begin
      total++;
      bad++;
      $display("FAIL sync_refresh: app_rdy=%b, required a low-to-high edge", app_rdy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete} !== 5'b0
        || app_rd_data !== 128'h0) begin
      bad++;
      $display("FAIL %s: rdy=%b wdf_rdy=%b valid=%b end=%b calib=%b data=%h, required all 0",
               name, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
               init_calib_complete, app_rd_data);
    end
  endtask

  task automatic wait_calib(output int n, output bit rdy_early);
    n = 0;
    rdy_early = 0;
    do begin
      tick();
      n++;
      if (init_calib_complete !== 1'b1 && app_rdy !== 1'b0) rdy_early = 1;
    end while (init_calib_complete !== 1'b1 && n < 40);
  endtask

  task automatic test_reset();
    int n;
    bit early;
    wait_cycles(3);
    check_reset_outputs("reset_outputs");
    mrst = 1'b0;
    wait_calib(n, early);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL calib_latency: got %0d cycles, required 16", n);
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL rdy_before_calib: got app_rdy=1 before calibration, required 0");
    end
    total++;
    if (app_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rdy_after_calib: got %b, required 1", app_rdy);
    end
  endtask

  task automatic test_write_read();
    int seen0, budget;
    sync_refresh();
    wr_cmd(28'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000);
    wr_data(128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000);
    seen0 = rd_seen;
    rd_exp(28'h40, 128'h0123456789ABCDEF0123456789ABCDEF);
    budget = 0;
    while (rd_seen == seen0 && budget < 50) begin tick(); budget++; end
    total++;
    if (last_valid_cyc - acc_cyc != 4) begin
      bad++;
      $display("FAIL rd_latency: got %0d cycles, required 4", last_valid_cyc - acc_cyc);
    end
    drain();
  endtask

  task automatic test_mask();
    sync_refresh();
    wr_cmd(28'h80, {128{1'b1}}, 16'h0000);
    wr_data({128{1'b1}}, 16'h0000);
    wr_cmd(28'h80, 128'h0, 16'h00FF);
    wr_data(128'h0, 16'h00FF);
    rd_exp(28'h80, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    drain();
  endtask

  task automatic test_data_late();
    int seen0;
    sync_refresh();
    wr_cmd(28'hC0, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'h0000);
    rd(28'hC0);
    seen0 = rd_seen;
    wait_cycles(5);
    total++;
    if (rd_seen != seen0) begin
      bad++;
      $display("FAIL read_overtook_write: got %0d responses, required 0", rd_seen - seen0);
    end
    wr_data(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'h0000);
    drain();
  endtask

  task automatic test_wdf_full();
    logic [127:0] d;
    sync_refresh();
    for (int i = 0; i < 4; i++) begin
      d = {4{32'hA5A50000 + 32'(i)}};
      wr_data(d, 16'h0000);
    end
    total++;
    if (app_wdf_rdy !== 1'b0) begin
      bad++;
      $display("FAIL wdf_full: got app_wdf_rdy=%b, required 0", app_wdf_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      d = {4{32'hA5A50000 + 32'(i)}};
      wr_cmd(28'h200 + 28'(i * 8), d, 16'h0000);
    end
    for (int i = 0; i < 4; i++) rd(28'h200 + 28'(i * 8));
    drain();
  endtask

  task automatic test_full();
    int seen0;
    sync_refresh();
    seen0 = rd_seen;
    wr_cmd(28'h100, 128'h11112222_33334444_55556666_77778888, 16'h0000);
    rd(28'h100);
    rd(28'h40);
    rd(28'h80);
    total++;
    if (app_rdy !== 1'b0) begin
      bad++;
      $display("FAIL cq_full: got app_rdy=%b, required 0 with 4 queued", app_rdy);
    end
    wait_cycles(3);
    total++;
    if (app_rdy !== 1'b0 || rd_seen != seen0) begin
      bad++;
      $display("FAIL cq_stall: got app_rdy=%b responses=%0d, required 0 and 0", app_rdy,
               rd_seen - seen0);
    end
    wr_data(128'h11112222_33334444_55556666_77778888, 16'h0000);
    rd(28'hC0);
    rd(28'h100);
    rd(28'h40);
    drain();
    total++;
    if (rd_seen - seen0 != 6) begin
      bad++;
      $display("FAIL full_count: got %0d responses, required 6", rd_seen - seen0);
    end
  endtask

  task automatic test_bad_cmd();
    int seen0;
    bit ok;
    sync_refresh();
    seen0 = rd_seen;
    issue(3'b010, 28'h40, ok);
    issue(3'b111, 28'h80, ok);
    rd(28'h40);
    drain();
    wait_cycles(8);
    total++;
    if (rd_seen - seen0 != 1) begin
      bad++;
      $display("FAIL bad_cmd: got %0d responses, required 1", rd_seen - seen0);
    end
  endtask

  task automatic test_refresh();
    int lows, highs, budget;
    bit wdf_dropped;
    budget = 0;
    while (app_rdy !== 1'b0 && budget < 100) begin tick(); budget++; end
    lows = 0;
    wdf_dropped = 0;
    while (app_rdy === 1'b0 && lows < 60) begin
      if (app_wdf_rdy !== 1'b1) wdf_dropped = 1;
      lows++;
      tick();
    end
    highs = 0;
    while (app_rdy === 1'b1 && highs < 60) begin highs++; tick(); end
    total++;
    if (lows != 8) begin
      bad++;
      $display("FAIL refresh_len: got %0d cycles, required 8", lows);
    end
    total++;
    if (highs != 32) begin
      bad++;
      $display("FAIL refresh_period: got %0d ready cycles, required 32", highs);
    end
    total++;
    if (wdf_dropped) begin
      bad++;
      $display("FAIL wdf_in_refresh: got app_wdf_rdy=0 during refresh, required 1");
    end
  endtask

  task automatic test_reset_mid();
    int seen0, n;
    bit early;
    sync_refresh();
    rd(28'h40);
    rd(28'h80);
    rd(28'hC0);
    mrst = 1'b1;
    exp_q.delete();
    seen0 = rd_seen;
    wait_cycles(2);
    check_reset_outputs("reset_mid_outputs");
    mrst = 1'b0;
    wait_calib(n, early);
    wait_cycles(10);
    total++;
    if (rd_seen != seen0) begin
      bad++;
      $display("FAIL reset_drop: got %0d responses after reset, required 0", rd_seen - seen0);
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL recalib_latency: got %0d cycles, required 16", n);
    end
    rd_exp(28'h40, 128'h0123456789ABCDEF0123456789ABCDEF);
    rd(28'h80);
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_data_late();
    test_wdf_full();
    test_full();
    test_bad_cmd();
    test_refresh();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
